jtframe_pocket_dwnld: RTL and testbench

Converts Analogue Pocket bridge write traffic into the byte-wide ioctl download stream that the Pocket top level consumes (`ioctl_addr`, `ioctl_dout`, `ioctl_wr`, `downloading`). It sits directly upstream of the Pocket frame wrapper in the `clk_sys` domain. It buffers 32-bit big-endian bridge words in a small FIFO and serialises them into paced byte writes. It also exposes a control/status register on the bridge.

---
 rtl/jtframe_pocket_dwnld.sv | 206 ++++++++++++++++++++
 tb/tb_jtframe_pocket_dwnld.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_pocket_dwnld.sv
// rtl/jtframe_pocket_dwnld.sv - Pocket bridge writes to paced byte-wide ioctl download stream
module jtframe_pocket_dwnld #(
    parameter logic [31:0] DATA_BASE = 32'h1000_0000,
    parameter logic [31:0] CTRL_ADDR = 32'hF800_0000,
    parameter int          FIFO_AW   = 2,
    parameter int          WR_GAP    = 4
)(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] bridge_addr,
    input  logic        bridge_wr,
    input  logic [31:0] bridge_wr_data,
    input  logic        bridge_rd,
    output logic [31:0] bridge_rd_data,
    output logic [24:0] ioctl_addr,
    output logic [7:0]  ioctl_dout,
    output logic        ioctl_wr,
    output logic        downloading,
    output logic        overflow
);
    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic [1:0] {IDLE, EMIT, GAP} state_t;

    // FIFO entry: word address (23 bits) above the 32-bit data word
    logic [54:0]        mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]   level_q;

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic        last_q, last_d;
    logic [3:0]  gap_q, gap_d;
    logic [31:0] word_q, word_d;
    logic [22:0] waddr_q, waddr_d;
    logic        out_load;
    logic [7:0]  out_byte;
    logic [24:0] out_addr;

    logic        downloading_q, overflow_q, end_pend_q;
    logic [15:0] word_cnt_q;
    logic [31:0] rd_data_q;
    logic [24:0] ioctl_addr_q;
    logic [7:0]  ioctl_dout_q;
    logic        ioctl_wr_q;

    logic is_data, is_ctrl_wr, is_ctrl_rd, empty, full, pop, push_req, push, drop;
    logic [54:0] head;

    assign is_data    = bridge_wr && (bridge_addr[31:25] == DATA_BASE[31:25]);
    assign is_ctrl_wr = bridge_wr && (bridge_addr == CTRL_ADDR);
    assign is_ctrl_rd = bridge_rd && (bridge_addr == CTRL_ADDR);
    assign empty      = (level_q == '0);
    assign full       = (level_q == (FIFO_AW+1)'(DEPTH));
    assign pop        = (state_q == IDLE) && !empty;
    assign push_req   = is_data && downloading_q;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign push       = push_req && (!full || pop);
    assign drop       = push_req && full && !pop;
    assign head       = mem[rd_ptr_q];

    function automatic logic [7:0] pick(input logic [31:0] w, input logic [1:0] i);
        case (i)
            2'd0:    pick = w[31:24];
            2'd1:    pick = w[23:16];
            2'd2:    pick = w[15:8];
            default: pick = w[7:0];
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= {bridge_addr[24:2], bridge_wr_data};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        last_d   = last_q;
        gap_d    = gap_q;
        word_d   = word_q;
        waddr_d  = waddr_q;
        out_load = 1'b0;
        out_byte = pick(word_q, idx_q);
        out_addr = {waddr_q, idx_q};
        case (state_q)
            IDLE: if (!empty) begin
                word_d   = head[31:0];
                waddr_d  = head[54:32];
                idx_d    = 2'd0;
                last_d   = 1'b0;
                state_d  = EMIT;
                out_load = 1'b1;
                out_byte = head[31:24];
                out_addr = {head[54:32], 2'd0};
            end
            EMIT: begin
                idx_d  = idx_q + 2'd1;
                last_d = (idx_q == 2'd3);
                gap_d  = 4'(WR_GAP - 1);
                // With no gap the next byte follows immediately
                if (WR_GAP == 1) begin
                    if (idx_q == 2'd3) state_d = IDLE;
                    else begin
                        state_d  = EMIT;
                        out_load = 1'b1;
                        out_byte = pick(word_q, idx_d);
                        out_addr = {waddr_q, idx_d};
                    end
                end else begin
                    state_d = GAP;
                end
            end
            GAP: begin
                if (gap_q <= 4'd1) begin
                    if (last_q) state_d = IDLE;
                    else begin
                        state_d  = EMIT;
                        out_load = 1'b1;
                    end
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            last_q       <= 1'b0;
            gap_q        <= '0;
            word_q       <= '0;
            waddr_q      <= '0;
            ioctl_addr_q <= '0;
            ioctl_dout_q <= '0;
            ioctl_wr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            last_q     <= last_d;
            gap_q      <= gap_d;
            word_q     <= word_d;
            waddr_q    <= waddr_d;
            ioctl_wr_q <= (state_d == EMIT);
            if (out_load) begin
                ioctl_addr_q <= out_addr;
                ioctl_dout_q <= out_byte;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            downloading_q <= 1'b0;
            overflow_q    <= 1'b0;
            end_pend_q    <= 1'b0;
            word_cnt_q    <= '0;
            rd_data_q     <= '0;
        end else begin
            if (is_ctrl_wr && bridge_wr_data[0]) begin
                downloading_q <= 1'b1;
                overflow_q    <= 1'b0;
                end_pend_q    <= 1'b0;
                word_cnt_q    <= '0;
            end else begin
                if (is_ctrl_wr && downloading_q) begin
                    end_pend_q <= 1'b1;
                end else if (end_pend_q && empty && state_q == IDLE) begin
                    downloading_q <= 1'b0;
                    end_pend_q    <= 1'b0;
                end
                if (drop) overflow_q <= 1'b1;
                if (pop && word_cnt_q != 16'hFFFF) word_cnt_q <= word_cnt_q + 16'd1;
            end
            if (bridge_rd) begin
                rd_data_q <= is_ctrl_rd ? {downloading_q, overflow_q, end_pend_q, 5'd0,
                                           8'(level_q), word_cnt_q} : 32'd0;
            end
        end
    end

    assign bridge_rd_data = rd_data_q;
    assign ioctl_addr     = ioctl_addr_q;
    assign ioctl_dout     = ioctl_dout_q;
    assign ioctl_wr       = ioctl_wr_q;
    assign downloading    = downloading_q;
    assign overflow       = overflow_q;
endmodule

// File: tb/tb_jtframe_pocket_dwnld.sv
// tb/tb_jtframe_pocket_dwnld.sv - directed bench for jtframe_pocket_dwnld
module tb_jtframe_pocket_dwnld;
    localparam logic [31:0] DB = 32'h1000_0000;
    localparam logic [31:0] CA = 32'hF800_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] bridge_addr = '0;
    logic        bridge_wr = 1'b0;
    logic [31:0] bridge_wr_data = '0;
    logic        bridge_rd = 1'b0;
    logic [31:0] bridge_rd_data;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wr;
    logic        downloading;
    logic        overflow;

    always #5 clk = ~clk;

    jtframe_pocket_dwnld #(.DATA_BASE(DB), .CTRL_ADDR(CA), .FIFO_AW(2), .WR_GAP(4)) dut (
        .clk(clk), .rst(rst),
        .bridge_addr(bridge_addr), .bridge_wr(bridge_wr), .bridge_wr_data(bridge_wr_data),
        .bridge_rd(bridge_rd), .bridge_rd_data(bridge_rd_data),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr),
        .downloading(downloading), .overflow(overflow)
    );

    int          cyc = 0;
    int          n_checks = 0;
    int          n_err = 0;
    int          t_wr = 0;
    int          fall_cyc = -1;
    logic        prev_dl = 1'b0;
    int          q_cyc[$];
    logic [24:0] q_addr[$];
    logic [7:0]  q_dout[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ioctl_wr) begin
            q_cyc.push_back(cyc);
            q_addr.push_back(ioctl_addr);
            q_dout.push_back(ioctl_dout);
        end
        if (prev_dl && !downloading) fall_cyc = cyc;
        prev_dl = downloading;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bridge_addr = a; bridge_wr_data = d; bridge_wr = 1'b1;
        t_wr = cyc;
        @(negedge clk);
        bridge_wr = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        bridge_addr = a; bridge_rd = 1'b1;
        @(negedge clk);
        bridge_rd = 1'b0;
        #1 d = bridge_rd_data;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_strobes(input int n, input int budget, input string tag);
        int k = 0;
        while (q_cyc.size() < n && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        check(tag, q_cyc.size(), n);
    endtask

    task automatic clear_q();
        q_cyc.delete(); q_addr.delete(); q_dout.delete();
    endtask

    logic [31:0] st;
    logic [7:0]  exp_b [4];

    initial begin
        exp_b[0] = 8'hA1; exp_b[1] = 8'hB2; exp_b[2] = 8'hC3; exp_b[3] = 8'hD4;

        idle(3); #1;
        check("rst ioctl_wr", ioctl_wr, 0);
        check("rst ioctl_addr", ioctl_addr, 0);
        check("rst ioctl_dout", ioctl_dout, 0);
        check("rst downloading", downloading, 0);
        check("rst overflow", overflow, 0);
        check("rst rd_data", bridge_rd_data, 0);
        rst = 1'b0;

        // ignored writes
        bus_write(DB, 32'hDEAD_BEEF);
        bus_write(CA, 32'd1);
        bus_write(32'h2000_0000, 32'h1234_5678);
        idle(30);
        check("ignored strobes", q_cyc.size(), 0);
        check("ignored overflow", overflow, 0);
        bus_read(CA, st);
        check("ignored status", st, 32'h8000_0000);

        // single word and end handshake
        clear_q();
        fall_cyc = -1;
        bus_write(DB + 32'd8, 32'hA1B2_C3D4);
        begin
            int t0;
            t0 = t_wr;
            idle(1);
            bus_write(CA, 32'd0);
            bus_read(CA, st);
            check("end_pend status", st, 32'hA000_0001);
            wait_strobes(4, 60, "single strobes");
            idle(12);
            if (q_cyc.size() >= 4) begin
                for (int i = 0; i < 4; i++) begin
                    check($sformatf("single cyc%0d", i), q_cyc[i] - t0, 2 + 4 * i);
                    check($sformatf("single addr%0d", i), q_addr[i], 8 + i);
                    check($sformatf("single dout%0d", i), q_dout[i], exp_b[i]);
                end
            end
            check("end fall cycle", fall_cyc - t0, 19);
            check("end downloading", downloading, 0);
        end

        // counter and read
        clear_q();
        bus_write(CA, 32'd1);
        bus_write(DB + 32'h10, 32'h1122_3344);
        bus_write(DB + 32'h14, 32'h5566_7788);
        bus_write(DB + 32'h18, 32'h99AA_BBCC);
        wait_strobes(12, 150, "count strobes");
        idle(5);
        bus_read(CA, st);
        check("count status", st, 32'h8000_0003);
        if (q_cyc.size() >= 12) begin
            check("count word gap", q_cyc[4] - q_cyc[3], 5);
            check("count last addr", q_addr[11], 25'h1B);
            check("count last dout", q_dout[11], 8'hCC);
            check("count first dout", q_dout[0], 8'h11);
        end

        // overflow
        clear_q();
        bus_write(CA, 32'd1);
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            bridge_addr = DB + 32'(4 * i);
            bridge_wr_data = 32'hF000_0000 | 32'(i);
            bridge_wr = 1'b1;
            @(negedge clk);
        end
        bridge_wr = 1'b0;
        wait_strobes(20, 200, "ovf strobes");
        idle(40);
        check("ovf strobe total", q_cyc.size(), 20);
        check("ovf flag", overflow, 1);
        bus_read(CA, st);
        check("ovf status", st, 32'hC000_0005);
        if (q_cyc.size() >= 20) begin
            check("ovf last addr", q_addr[19], 25'd19);
            check("ovf last dout", q_dout[19], 8'h04);
        end

        // reset mid-download
        clear_q();
        bus_write(CA, 32'd1);
        check("restart clears ovf", overflow, 0);
        bus_write(DB, 32'h1234_5678);
        wait_strobes(2, 40, "mid strobes");
        rst = 1'b1;
        #1;
        check("mid ioctl_wr", ioctl_wr, 0);
        check("mid ioctl_addr", ioctl_addr, 0);
        check("mid ioctl_dout", ioctl_dout, 0);
        check("mid downloading", downloading, 0);
        idle(10);
        rst = 1'b0;
        idle(30);
        check("mid no more strobes", q_cyc.size(), 2);
        bus_read(CA, st);
        check("mid status", st, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
